// File: rtl/id_stage_pkg.sv
// -----------------------------------------------------------------------------
// id_stage_pkg
// Shared RV32I decode definitions: the ALU opcode encoding (also used by the
// ALU in EX), major opcode and funct3/funct7 constants, the immediate-format
// selector and the decoded-control bundle carried from ID to EX.
// -----------------------------------------------------------------------------
package id_stage_pkg;

  // ALU opcode encoding shared with the EX-stage ALU.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_LUI  = 4'b1001,  // pass src2
    ALU_JALR = 4'b1010,  // (a + b) & ~1
    ALU_SRA  = 4'b1101
  } alu_op_e;

  // Major opcodes (inst[6:0]).
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // funct3 values that steer decode.
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;

  // funct7 values for OP and shift-immediate instructions.
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Immediate formats produced by imm_gen.
  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_SHAMT,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  // Decoded control bundle registered between ID and EX.
  typedef struct packed {
    alu_op_e     alu_op;
    logic        src1_sel;
    logic        src2_sel;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_we;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  mem_size;
    logic        branch;
    logic        jump;
    logic        illegal;
  } dec_t;

  // Legal funct3 codes for the memory and branch classes.
  function automatic logic f3_legal(input logic [6:0] opc, input logic [2:0] f3);
    logic ok;
    ok = 1'b1;
    case (opc)
      OPC_LOAD:   ok = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
      OPC_STORE:  ok = (f3 <= 3'b010);
      OPC_BRANCH: ok = (f3 != 3'b010) && (f3 != 3'b011);
      default:    ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/id_stage_imm_gen.sv
// -----------------------------------------------------------------------------
// imm_gen
// Combinational RV32I immediate generator. Every format is sign-extended from
// inst[31] except the shift amount, which is a zero-extended 5-bit field.
// Ports:
//   i_inst  in   32  instruction word
//   i_fmt   in   3   immediate format selector
//   o_imm   out  32  immediate value (0 for formats without an immediate)
// -----------------------------------------------------------------------------
module imm_gen
  import id_stage_pkg::*;
(
  input  logic [31:0] i_inst,
  input  imm_fmt_e    i_fmt,
  output logic [31:0] o_imm
);

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path through the case leaves it unassigned and infers a latch.
    o_imm = '0;
    case (i_fmt)
      IMM_I:     o_imm = {{20{i_inst[31]}}, i_inst[31:20]};
      IMM_SHAMT: o_imm = {27'd0, i_inst[24:20]};
      IMM_S:     o_imm = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
      IMM_B:     o_imm = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
      IMM_U:     o_imm = {i_inst[31:12], 12'd0};
      IMM_J:     o_imm = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
      default:   o_imm = '0;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// -----------------------------------------------------------------------------
// id_stage
// RV32I instruction-decode stage. Decodes the instruction offered by IF into
// ALU opcode, operand selects, immediate and control flags, registers the
// result once and holds it under a valid/ready handshake toward EX.
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   if_valid/if_ready        IF -> ID handshake (if_ready = ~id_valid | ex_ready)
//   if_pc, if_inst           PC and instruction word from IF
//   flush                    kills ID contents; wins over a simultaneous capture
//   ex_ready, id_valid       ID -> EX handshake
//   id_pc                    registered PC
//   alu_op, src1_sel, src2_sel, imm, rs1, rs2, rd   ALU interface
//   reg_we, mem_read, mem_write, mem_size, branch, jump, illegal   controls
// Parameter:
//   ILLEGAL_AS_NOP  1: illegal encodings issue as a NOP with illegal=1;
//                   0: they issue with their controls as decoded.
// -----------------------------------------------------------------------------
module id_stage
  import id_stage_pkg::*;
#(
  parameter bit ILLEGAL_AS_NOP = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  output logic        if_ready,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_inst,
  input  logic        flush,
  input  logic        ex_ready,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [3:0]  alu_op,
  output logic        src1_sel,
  output logic        src2_sel,
  output logic [31:0] imm,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        reg_we,
  output logic        mem_read,
  output logic        mem_write,
  output logic [2:0]  mem_size,
  output logic        branch,
  output logic        jump,
  output logic        illegal
);

  logic [6:0]  w_opc;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  imm_fmt_e    w_fmt;
  logic [31:0] w_imm;
  dec_t        w_raw;
  dec_t        w_dec;
  logic        w_capture;

  logic        r_valid;
  logic [31:0] r_pc;
  dec_t        r_dec;

  assign w_opc = if_inst[6:0];
  assign w_f3  = if_inst[14:12];
  assign w_f7  = if_inst[31:25];

  imm_gen u_imm_gen (
    .i_inst (if_inst),
    .i_fmt  (w_fmt),
    .o_imm  (w_imm)
  );

  // Per-class decode; the immediate is merged in below from imm_gen.
  always_comb begin
    w_raw        = '0;
    w_fmt        = IMM_NONE;
    w_raw.alu_op = ALU_ADD;
    w_raw.rs1    = if_inst[19:15];
    w_raw.rs2    = if_inst[24:20];
    w_raw.rd     = if_inst[11:7];

    if (if_inst[1:0] != 2'b11) begin
      w_raw.illegal = 1'b1;
    end else begin
      case (w_opc)
        OPC_OP: begin
          w_raw.alu_op = alu_op_e'({1'b0, w_f3});
          w_raw.reg_we = 1'b1;
          if (w_f7 == F7_ALT) begin
            if (w_f3 == F3_ADD_SUB)      w_raw.alu_op  = ALU_SUB;
            else if (w_f3 == F3_SRL_SRA) w_raw.alu_op  = ALU_SRA;
            else                         w_raw.illegal = 1'b1;
          end else if (w_f7 != F7_BASE) begin
            w_raw.illegal = 1'b1;
          end
        end
        OPC_OP_IMM: begin
          w_raw.src2_sel = 1'b1;
          w_raw.reg_we   = 1'b1;
          w_raw.alu_op   = alu_op_e'({1'b0, w_f3});
          w_fmt          = IMM_I;
          if (w_f3 == F3_SLL) begin
            w_fmt         = IMM_SHAMT;
            w_raw.illegal = (w_f7 != F7_BASE);
          end else if (w_f3 == F3_SRL_SRA) begin
            w_fmt = IMM_SHAMT;
            if (w_f7 == F7_ALT)        w_raw.alu_op  = ALU_SRA;
            else if (w_f7 != F7_BASE)  w_raw.illegal = 1'b1;
          end
        end
        OPC_LOAD: begin
          w_raw.src2_sel = 1'b1;
          w_raw.reg_we   = 1'b1;
          w_raw.mem_read = 1'b1;
          w_raw.mem_size = w_f3;
          w_raw.illegal  = !f3_legal(w_opc, w_f3);
          w_fmt          = IMM_I;
        end
        OPC_STORE: begin
          w_raw.src2_sel  = 1'b1;
          w_raw.mem_write = 1'b1;
          w_raw.mem_size  = w_f3;
          w_raw.illegal   = !f3_legal(w_opc, w_f3);
          w_fmt           = IMM_S;
        end
        OPC_BRANCH: begin
          // The ALU computes the target; the comparison type rides in mem_size.
          w_raw.src1_sel = 1'b1;
          w_raw.src2_sel = 1'b1;
          w_raw.branch   = 1'b1;
          w_raw.mem_size = w_f3;
          w_raw.illegal  = !f3_legal(w_opc, w_f3);
          w_fmt          = IMM_B;
        end
        OPC_JAL: begin
          w_raw.src1_sel = 1'b1;
          w_raw.src2_sel = 1'b1;
          w_raw.jump     = 1'b1;
          w_raw.reg_we   = 1'b1;
          w_fmt          = IMM_J;
        end
        OPC_JALR: begin
          w_raw.alu_op   = ALU_JALR;
          w_raw.src2_sel = 1'b1;
          w_raw.jump     = 1'b1;
          w_raw.reg_we   = 1'b1;
          w_fmt          = IMM_I;
        end
        OPC_LUI: begin
          w_raw.alu_op   = ALU_LUI;
          w_raw.src2_sel = 1'b1;
          w_raw.reg_we   = 1'b1;
          w_fmt          = IMM_U;
        end
        OPC_AUIPC: begin
          w_raw.src1_sel = 1'b1;
          w_raw.src2_sel = 1'b1;
          w_raw.reg_we   = 1'b1;
          w_fmt          = IMM_U;
        end
        OPC_FENCE, OPC_SYSTEM: ;  // issued as a NOP
        default: w_raw.illegal = 1'b1;
      endcase
    end
  end

  // Merge the immediate, squash x0 writes and optionally turn illegal
  // encodings into a NOP that still carries the register fields.
  always_comb begin
    w_dec        = w_raw;
    w_dec.imm    = w_imm;
    w_dec.reg_we = w_raw.reg_we && (w_raw.rd != 5'd0);
    if (ILLEGAL_AS_NOP && w_raw.illegal) begin
      w_dec.alu_op    = ALU_ADD;
      w_dec.src1_sel  = 1'b0;
      w_dec.src2_sel  = 1'b0;
      w_dec.imm       = '0;
      w_dec.reg_we    = 1'b0;
      w_dec.mem_read  = 1'b0;
      w_dec.mem_write = 1'b0;
      w_dec.mem_size  = '0;
      w_dec.branch    = 1'b0;
      w_dec.jump      = 1'b0;
    end
  end

  assign if_ready  = ~r_valid | ex_ready;
  assign w_capture = if_valid & if_ready;

  // Output register. Payload only loads on a kept capture, so it stays frozen
  // while EX stalls.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
    if (rst) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_dec   <= '0;
    end else begin
      if (flush)          r_valid <= 1'b0;
      else if (w_capture) r_valid <= 1'b1;
      else if (ex_ready)  r_valid <= 1'b0;

      if (w_capture && !flush) begin
        r_pc  <= if_pc;
        r_dec <= w_dec;
      end
    end
  end

  assign id_valid  = r_valid;
  assign id_pc     = r_pc;
  assign alu_op    = r_dec.alu_op;
  assign src1_sel  = r_dec.src1_sel;
  assign src2_sel  = r_dec.src2_sel;
  assign imm       = r_dec.imm;
  assign rs1       = r_dec.rs1;
  assign rs2       = r_dec.rs2;
  assign rd        = r_dec.rd;
  assign reg_we    = r_dec.reg_we;
  assign mem_read  = r_dec.mem_read;
  assign mem_write = r_dec.mem_write;
  assign mem_size  = r_dec.mem_size;
  assign branch    = r_dec.branch;
  assign jump      = r_dec.jump;
  assign illegal   = r_dec.illegal;

endmodule

// File: tb/tb_id_stage.sv
// -----------------------------------------------------------------------------
// tb_id_stage
// Self-checking bench for id_stage: directed cases followed by randomized
// instructions and handshake traffic, compared against a behavioural model
// that decodes straight from the RV32I field rules.
// -----------------------------------------------------------------------------
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        flush;
  logic        ex_ready;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [3:0]  alu_op;
  logic        src1_sel;
  logic        src2_sel;
  logic [31:0] imm;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        reg_we;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  mem_size;
  logic        branch;
  logic        jump;
  logic        illegal;

  always #5 clk = ~clk;

  id_stage #(.ILLEGAL_AS_NOP(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_valid  (if_valid),
    .if_ready  (if_ready),
    .if_pc     (if_pc),
    .if_inst   (if_inst),
    .flush     (flush),
    .ex_ready  (ex_ready),
    .id_valid  (id_valid),
    .id_pc     (id_pc),
    .alu_op    (alu_op),
    .src1_sel  (src1_sel),
    .src2_sel  (src2_sel),
    .imm       (imm),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd),
    .reg_we    (reg_we),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_size  (mem_size),
    .branch    (branch),
    .jump      (jump),
    .illegal   (illegal)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  // Expected decode of one instruction.
  typedef struct {
    logic [3:0]  alu;
    logic        s1;
    logic        s2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        we;
    logic        mr;
    logic        mw;
    logic [2:0]  msz;
    logic        br;
    logic        jmp;
    logic        ill;
  } exp_t;

  // Reference decoder: fields pulled out with shifts and masks, immediates
  // assembled arithmetically, decision by instruction class.
  function automatic exp_t model_decode(input logic [31:0] inst);
    exp_t        e;
    int          opc, f3, f7;
    logic [31:0] sgn, i_imm, s_imm, b_imm, u_imm, j_imm, shamt;
    logic        writes;
    opc   = int'(inst & 32'h7f);
    f3    = int'((inst >> 12) & 32'h7);
    f7    = int'(inst >> 25);
    sgn   = inst[31] ? 32'hffff_ffff : 32'h0;
    i_imm = (sgn << 11) | ((inst >> 20) & 32'h7ff);
    s_imm = (sgn << 11) | (((inst >> 25) & 32'h3f) << 5) | ((inst >> 7) & 32'h1f);
    b_imm = (sgn << 12) | (((inst >> 7) & 32'h1) << 11) | (((inst >> 25) & 32'h3f) << 5)
          | (((inst >> 8) & 32'hf) << 1);
    u_imm = inst & 32'hffff_f000;
    j_imm = (sgn << 20) | (((inst >> 12) & 32'hff) << 12) | (((inst >> 20) & 32'h1) << 11)
          | (((inst >> 21) & 32'h3ff) << 1);
    shamt = (inst >> 20) & 32'h1f;

    e.rs1 = 5'((inst >> 15) & 32'h1f);
    e.rs2 = 5'((inst >> 20) & 32'h1f);
    e.rd  = 5'((inst >> 7) & 32'h1f);
    e.alu = 4'd0; e.s1 = 0; e.s2 = 0; e.imm = 0; e.we = 0; e.mr = 0; e.mw = 0;
    e.msz = 3'd0; e.br = 0; e.jmp = 0; e.ill = 0;
    writes = 0;

    if ((inst & 32'h3) != 32'h3) e.ill = 1;
    else if (opc == 'h33) begin              // OP
      writes = 1;
      if (f7 == 0)                     e.alu = 4'(f3);
      else if (f7 == 'h20 && f3 == 0)  e.alu = 4'd8;
      else if (f7 == 'h20 && f3 == 5)  e.alu = 4'd13;
      else                             e.ill = 1;
    end else if (opc == 'h13) begin          // OP-IMM
      writes = 1; e.s2 = 1;
      if (f3 == 1) begin
        e.alu = 4'd1; e.imm = shamt; e.ill = (f7 != 0);
      end else if (f3 == 5) begin
        e.imm = shamt;
        if (f7 == 0)         e.alu = 4'd5;
        else if (f7 == 'h20) e.alu = 4'd13;
        else                 e.ill = 1;
      end else begin
        e.alu = 4'(f3); e.imm = i_imm;
      end
    end else if (opc == 'h03) begin          // LOAD
      writes = 1; e.s2 = 1; e.mr = 1; e.msz = 3'(f3); e.imm = i_imm;
      e.ill = !(f3 inside {0, 1, 2, 4, 5});
    end else if (opc == 'h23) begin          // STORE
      e.s2 = 1; e.mw = 1; e.msz = 3'(f3); e.imm = s_imm;
      e.ill = !(f3 inside {0, 1, 2});
    end else if (opc == 'h63) begin          // BRANCH
      e.s1 = 1; e.s2 = 1; e.br = 1; e.msz = 3'(f3); e.imm = b_imm;
      e.ill = (f3 == 2 || f3 == 3);
    end else if (opc == 'h6f) begin          // JAL
      writes = 1; e.s1 = 1; e.s2 = 1; e.jmp = 1; e.imm = j_imm;
    end else if (opc == 'h67) begin          // JALR
      writes = 1; e.alu = 4'd10; e.s2 = 1; e.jmp = 1; e.imm = i_imm;
    end else if (opc == 'h37) begin          // LUI
      writes = 1; e.alu = 4'd9; e.s2 = 1; e.imm = u_imm;
    end else if (opc == 'h17) begin          // AUIPC
      writes = 1; e.s1 = 1; e.s2 = 1; e.imm = u_imm;
    end else if (opc == 'h0f || opc == 'h73) begin
      // FENCE / SYSTEM: NOP
    end else e.ill = 1;

    e.we = writes && (e.rd != 0);
    if (e.ill) begin                         // issued as a NOP
      e.alu = 4'd0; e.s1 = 0; e.s2 = 0; e.imm = 0; e.we = 0; e.mr = 0;
      e.mw = 0; e.msz = 3'd0; e.br = 0; e.jmp = 0;
    end
    return e;
  endfunction

  // Model of the stage register.
  logic        m_valid;
  logic [31:0] m_pc;
  exp_t        m_dec;

  task automatic compare_outputs();
    check("id_valid", 32'(id_valid), 32'(m_valid));
    if (m_valid) begin
      check("id_pc",     id_pc,            m_pc);
      check("alu_op",    32'(alu_op),      32'(m_dec.alu));
      check("src1_sel",  32'(src1_sel),    32'(m_dec.s1));
      check("src2_sel",  32'(src2_sel),    32'(m_dec.s2));
      check("imm",       imm,              m_dec.imm);
      check("rs1",       32'(rs1),         32'(m_dec.rs1));
      check("rs2",       32'(rs2),         32'(m_dec.rs2));
      check("rd",        32'(rd),          32'(m_dec.rd));
      check("reg_we",    32'(reg_we),      32'(m_dec.we));
      check("mem_read",  32'(mem_read),    32'(m_dec.mr));
      check("mem_write", 32'(mem_write),   32'(m_dec.mw));
      check("mem_size",  32'(mem_size),    32'(m_dec.msz));
      check("branch",    32'(branch),      32'(m_dec.br));
      check("jump",      32'(jump),        32'(m_dec.jmp));
      check("illegal",   32'(illegal),     32'(m_dec.ill));
    end
  endtask

  task automatic check_all_zero(input string tag);
    logic [31:0] packed_or;
    check({tag, "_id_valid"}, 32'(id_valid), 32'd0);
    check({tag, "_id_pc"},    id_pc,         32'd0);
    check({tag, "_imm"},      imm,           32'd0);
    check({tag, "_alu_op"},   32'(alu_op),   32'd0);
    packed_or = 32'({src1_sel, src2_sel, rs1, rs2, rd, reg_we, mem_read, mem_write,
                     mem_size, branch, jump, illegal});
    check({tag, "_ctrl"},     packed_or,     32'd0);
  endtask

  // One cycle: drive inputs, check the handshake, clock, update the model,
  // compare outputs. Entered and left 1 time unit after a rising edge.
  task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                      input logic fl, input logic er);
    logic cap;
    if_valid = v; if_inst = inst; if_pc = pc; flush = fl; ex_ready = er;
    #1;
    check("if_ready", 32'(if_ready), 32'(!m_valid || er));
    cap = v && (!m_valid || er);
    @(posedge clk);
    if (fl)       m_valid = 1'b0;
    else if (cap) begin m_valid = 1'b1; m_pc = pc; m_dec = model_decode(inst); end
    else if (er)  m_valid = 1'b0;
    #1;
    compare_outputs();
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    logic [6:0]  opcs [11];
    int          k;
    opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17, 7'h0f, 7'h73};
    w = $urandom;
    k = $urandom_range(0, 11);
    if (k < 11) begin
      w[6:0] = opcs[k];
      case ($urandom_range(0, 3))
        0:       w[31:25] = 7'h00;
        1:       w[31:25] = 7'h20;
        default: ;
      endcase
      if ($urandom_range(0, 15) == 0) w[1:0] = 2'($urandom_range(0, 2));
    end
    return w;
  endfunction

  localparam logic [31:0] I_ADDI     = 32'hFFB1_0093;
  localparam logic [31:0] I_SRAI     = 32'h4022_5193;
  localparam logic [31:0] I_SRAI_BAD = 32'h4222_5193;
  localparam logic [31:0] I_LUI      = 32'h1234_52B7;
  localparam logic [31:0] I_SUB_X0   = 32'h4030_8033;
  localparam logic [31:0] I_XOR      = 32'h0031_4133;  // xor x2,x2,x3

  initial begin
    rst = 1'b0; if_valid = 0; if_inst = 0; if_pc = 0; flush = 0; ex_ready = 0;
    m_valid = 1'b0; m_pc = '0; m_dec = model_decode(32'h0000_0013);
    #2 rst = 1'b1;
    #1 check_all_zero("reset");
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;

    // ADDI x1,x2,-5
    step(1, I_ADDI, 32'h0000_1000, 0, 1);
    check("addi_alu",  32'(alu_op),   32'h0);
    check("addi_src2", 32'(src2_sel), 32'h1);
    check("addi_imm",  imm,           32'hFFFF_FFFB);
    check("addi_rs1",  32'(rs1),      32'd2);
    check("addi_rd",   32'(rd),       32'd1);
    check("addi_we",   32'(reg_we),   32'd1);

    step(1, I_SRAI, 32'h0000_1004, 0, 1);
    check("srai_alu", 32'(alu_op), 32'hD);
    check("srai_imm", imm,         32'd2);
    step(1, I_SRAI_BAD, 32'h0000_1008, 0, 1);
    check("srai_bad_ill", 32'(illegal), 32'd1);
    check("srai_bad_we",  32'(reg_we),  32'd0);
    step(1, I_LUI, 32'h0000_100C, 0, 1);
    check("lui_alu",  32'(alu_op),   32'h9);
    check("lui_imm",  imm,           32'h1234_5000);
    check("lui_src2", 32'(src2_sel), 32'd1);
    step(1, I_SUB_X0, 32'h0000_1010, 0, 1);
    check("sub_alu", 32'(alu_op), 32'h8);
    check("sub_we",  32'(reg_we), 32'd0);

    // EX stalls for 3 cycles with IF offering a new instruction.
    for (int i = 0; i < 3; i++) begin
      step(1, I_LUI, 32'h0000_2000, 0, 0);
      check("hold_if_ready", 32'(if_ready), 32'd0);
      check("hold_alu",      32'(alu_op),   32'h8);
    end
    step(1, I_LUI, 32'h0000_2000, 0, 1);
    check("release_alu", 32'(alu_op), 32'h9);
    check("release_pc",  id_pc,       32'h0000_2000);

    // Flush together with a capture drops the instruction.
    step(1, I_ADDI, 32'h0000_3000, 1, 1);
    check("flush_valid", 32'(id_valid), 32'd0);
    step(1, I_XOR, 32'h0000_3004, 0, 1);
    check("after_flush_alu", 32'(alu_op), 32'h4);

    // Asynchronous reset between clock edges.
    step(1, I_ADDI, 32'h0000_4000, 0, 1);
    #2 rst = 1'b1;
    #1 check_all_zero("async_rst");
    m_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    step(1, I_SRAI, 32'h0000_4004, 0, 1);
    check("post_rst_alu", 32'(alu_op), 32'hD);

    // Randomized instructions and handshake traffic.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 3) != 0), rand_inst(), $urandom & 32'hFFFF_FFFC,
           1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
